// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
package axis_pkg;

    typedef enum logic {
        S_HEADER,
        S_PAYLOAD
    } hdr_state_t;

    // Widest header the helper can build; both fields must fit in 32 bits.
    localparam int unsigned HDR_MAX_W = 64;

    function automatic logic [HDR_MAX_W-1:0] make_header(
        input logic [31:0] seq,
        input logic [31:0] len,
        input int unsigned len_width
    );
        return ({32'd0, seq} << len_width) | {32'd0, len};
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry AXI-Stream output register: loads when free, holds while stalled.
module axis_pipe_reg #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  free_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    always_comb begin
        free_o  = !valid_q || ready_i;
        // The owner only raises load_i while free_o is high.
        valid_d = load_i || (valid_q && !ready_i);
        data_d  = load_i ? data_i : data_q;
        last_d  = load_i ? last_i : last_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a {seq, length} header beat to each tlast-framed packet and flags
// packets whose payload length differs from the length carried in the header.
module axis_header_inserter
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned SEQ_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  len_err,
    output logic [15:0]           err_count
);

    if (DATA_WIDTH < LEN_WIDTH + SEQ_WIDTH || LEN_WIDTH > 32 || SEQ_WIDTH > 32)
    begin : g_width_check
        $error("axis_header_inserter: DATA_WIDTH must hold LEN_WIDTH + SEQ_WIDTH");
    end

    hdr_state_t            state_q, state_d;
    logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]  exp_len_q, exp_len_d;
    logic [15:0]           err_count_q, err_count_d;
    logic                  len_err_q, len_err_d;

    logic                  reg_free;
    logic                  reg_load;
    logic [DATA_WIDTH-1:0] reg_data;
    logic                  reg_last;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  len_mismatch;

    assign hdr_word = DATA_WIDTH'(make_header(32'(seq_q), 32'(length), LEN_WIDTH));

    // Extra bit so a saturated counter still compares correctly.
    assign len_mismatch = ({1'b0, beat_cnt_q} + (LEN_WIDTH + 1)'(1)) != {1'b0, exp_len_q};

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        beat_cnt_d    = beat_cnt_q;
        exp_len_d     = exp_len_q;
        err_count_d   = err_count_q;
        len_err_d     = 1'b0;
        reg_load      = 1'b0;
        reg_data      = s_axis_tdata;
        reg_last      = s_axis_tlast;
        s_axis_tready = 1'b0;

        unique case (state_q)
            S_HEADER: begin
                // Header only goes out once a payload beat is waiting.
                if (s_axis_tvalid && reg_free) begin
                    reg_load  = 1'b1;
                    reg_data  = hdr_word;
                    reg_last  = 1'b0;
                    exp_len_d = length;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                s_axis_tready = reg_free;
                if (s_axis_tvalid && reg_free) begin
                    reg_load = 1'b1;
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                    if (s_axis_tlast) begin
                        state_d    = S_HEADER;
                        seq_d      = seq_q + SEQ_WIDTH'(1);
                        beat_cnt_d = '0;
                        if (len_mismatch) begin
                            len_err_d = 1'b1;
                            if (err_count_q != 16'hFFFF) begin
                                err_count_d = err_count_q + 16'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_HEADER;
            seq_q       <= '0;
            beat_cnt_q  <= '0;
            exp_len_q   <= '0;
            err_count_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_len_q   <= exp_len_d;
            err_count_q <= err_count_d;
            len_err_q   <= len_err_d;
        end
    end

    axis_pipe_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .aclk    (aclk),
        .areset  (areset),
        .load_i  (reg_load),
        .data_i  (reg_data),
        .last_i  (reg_last),
        .ready_i (m_axis_tready),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .last_o  (m_axis_tlast),
        .free_o  (reg_free)
    );

    assign len_err   = len_err_q;
    assign err_count = err_count_q;

endmodule

// File: doc/axis_header_inserter.md
# axis_header_inserter

Prepends one header beat to every tlast-delimited AXI-Stream packet and forwards the payload unchanged. It sits directly downstream of the packetizer, which supplies packets framed with tlast. The header carries a wrapping sequence number and the expected payload length. The block checks the actual payload length against that expected value and flags mismatches.

## Interface
- `DATA_WIDTH`, 16: tdata width in bits.
- `LEN_WIDTH`, 8: width of the length field and the beat counter.
- `SEQ_WIDTH`, 8: width of the sequence-number field. Elaboration error unless `DATA_WIDTH >= LEN_WIDTH + SEQ_WIDTH`.
- `aclk` in 1: the single clock.
- `areset` in 1: asynchronous reset, active-high.
- `length` in LEN_WIDTH: expected payload beats per packet. Sampled when the header is loaded.
- `s_axis_tdata` in DATA_WIDTH: payload in.
- `s_axis_tvalid` in 1: payload valid.
- `s_axis_tlast` in 1: last payload beat.
- `s_axis_tready` out 1: payload ready.
- `m_axis_tdata` out DATA_WIDTH: header or payload out, registered.
- `m_axis_tvalid` out 1: output valid, registered.
- `m_axis_tlast` out 1: output last, registered.
- `m_axis_tready` in 1: downstream ready.
- `len_err` out 1: one-cycle pulse on a length mismatch.
- `err_count` out 16: saturating count of mismatches.

## Operation
- Two states: S_HEADER and S_PAYLOAD. Reset state is S_HEADER.
- The output register is free when `!m_axis_tvalid || m_axis_tready`.
- S_HEADER behaviour:
  - `s_axis_tready = 0`.
  - When `s_axis_tvalid` is high and the register is free, load the header beat and go to S_PAYLOAD.
  - A header is never emitted before the first payload beat is pending. No orphan headers.
- Header beat contents:
  - tdata = zero-extended `{seq, length}`, with seq in bits `[LEN_WIDTH+SEQ_WIDTH-1:LEN_WIDTH]` and length in `[LEN_WIDTH-1:0]`.
  - tlast = 0.
  - `length` is latched into `exp_len` in the same cycle.
- S_PAYLOAD behaviour:
  - `s_axis_tready` equals "register free".
  - Each accepted beat loads tdata and tlast unchanged and increments `beat_cnt`. `beat_cnt` saturates at `2^LEN_WIDTH-1`; it does not wrap.
  - When the beat with tlast is accepted: go to S_HEADER, increment `seq` (modulo `2^SEQ_WIDTH`), clear `beat_cnt`.
- Length check, performed at the accepted tlast beat:
  - Mismatch if `beat_cnt + 1` (LEN_WIDTH+1-bit compare) differs from `exp_len`.
  - On mismatch: `len_err` = 1 on the following cycle only, and `err_count` increments (saturating at 0xFFFF).
  - With `length == 0`, every packet mismatches.
  - Packets with a bad length are still forwarded intact.
- A `length` change while in S_PAYLOAD has no effect until the next header.
- Reset mid-packet: the partial packet is dropped and the next accepted beat starts a new header with `seq = 0`. No partial-packet recovery.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `len_err`=0, `err_count`=0, `seq`=0, `beat_cnt`=0, state=S_HEADER.
- Latency: one cycle from input acceptance to output valid, for both header and payload.
- Throughput: N+1 cycles per N-beat packet under continuous valid/ready. No bubble between the tlast beat and the next header.
- AXI-S rules:
  - While `m_axis_tvalid && !m_axis_tready`, `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` are held stable.
  - `s_axis_tready` may depend combinationally on `m_axis_tready` (single-register stage, no skid).
- `len_err` is registered. It asserts the cycle after the tlast beat is accepted on the slave side, regardless of when that beat leaves on the master side.

## Structure
- Package `axis_pkg` holds:
  - The `hdr_state_t` enum (S_HEADER, S_PAYLOAD).
  - The function `make_header(seq, len)`, which returns the zero-extended header word.
- Sub-module `axis_pipe_reg`: the single output register with load/hold and free logic. The FSM drives its load-enable and its data/last mux.
- The top holds the FSM, `seq`, `beat_cnt`, `exp_len` and the error logic. Target is 150–250 lines.

## Test plan
- Single packet:
  - Stimulus: `length`=4, 4 beats 0x0A..0x0D with tlast on 0x0D, `m_axis_tready`=1.
  - Required: output 0x0004, 0x0A, 0x0B, 0x0C, 0x0D(tlast); `len_err` never set.
- Back-to-back packets:
  - Stimulus: 3 packets of `length`=2, input valid continuously.
  - Required: headers 0x0002, 0x0102, 0x0202; 9 output beats in 9 consecutive cycles.
- Sequence wrap:
  - Stimulus: 257 packets of `length`=1.
  - Required: header of the 257th packet = 0x0001 (seq wrapped to 0).
- Length mismatch:
  - Stimulus: `length`=4, packet of 3 beats; then `length`=4, packet of 5 beats.
  - Required: `len_err` pulses once per packet, each 1 cycle wide; `err_count`=2; all 8 payload beats forwarded.
- Backpressure:
  - Stimulus: random `m_axis_tready` with 50% duty over 100 packets.
  - Required: output data/last stable while stalled; output stream equals the reference model; no lost or duplicated beats.
- Async reset mid-packet:
  - Stimulus: assert `areset` after 2 of 4 beats are accepted, then send a new 4-beat packet with `length`=4.
  - Required: all outputs 0 during reset; first output after reset is header 0x0004 (seq 0).
